// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the APB UART transmitter (and its future receiver).
//   - OVERSAMPLE      : baud ticks per serial bit
//   - uart_tx_state_t : transmitter FSM state encoding
//   - baud_divider()  : PCLK cycles per baud tick for a given clock/baud pair
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity state).
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START_BIT  = 3'd1,
        S_DATA_BITS  = 3'd2,
        S_PARITY_BIT = 3'd3,
        S_STOP_BIT   = 3'd4
    } uart_tx_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START_BIT = 2'd1,
        S_DATA_BITS = 2'd2,
        S_STOP_BIT  = 2'd3
    } uart_tx_state_t;
`endif

    // Integer division; any remainder shows up as a small baud-rate error.
    function automatic int unsigned baud_divider(input int unsigned clk_freq,
                                                 input int unsigned bps);
        return clk_freq / (bps * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
// Groups the transmitter's request/status/line signals.
//   tx_start : transmit request (single-cycle or level)
//   tx_data  : byte to send, sampled on the acceptance cycle
//   tx       : serial line, idle high
//   tx_busy  : frame in progress
//   tx_done  : one-cycle pulse at frame end
// Modports: master = register block side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Free-running baud counter producing one tick every DIVIDER_CNT cycles.
// Ports:
//   PCLK   : clock, rising edge
//   PRESET : synchronous active-low reset
//   clear  : hold the counter at 0 (phase-aligns the next frame)
//   tick   : combinational, high while the counter sits at DIVIDER_CNT-1
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int unsigned DIVIDER_CNT = 651
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] CNT_MAX = 16'(DIVIDER_CNT - 1);

    logic [15:0] baud_cnt_q;
    logic [15:0] baud_cnt_d;

    assign tick = (baud_cnt_q == CNT_MAX);

    always_comb begin
        baud_cnt_d = baud_cnt_q + 16'd1;
        if (clear || tick) begin
            baud_cnt_d = '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter with 16x oversampled bit timing and a single-frame
// transmit register (no FIFO). Requests arriving while busy are dropped.
// Ports:
//   PCLK   : clock, rising edge
//   PRESET : synchronous active-low reset
//   tx_if  : uart_tx_if.slave (tx_start, tx_data in; tx, tx_busy, tx_done out)
// Parameters: CLK_FREQ (Hz), BPS (baud).
// Optional feature macro: UART_TX_PARITY_EN -- inserts an even-parity bit
// between the data bits and the stop bit (11-bit frame).
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BPS      = 9600
) (
    input  logic    PCLK,
    input  logic    PRESET,
    uart_tx_if.slave tx_if
);

    localparam int unsigned DIVIDER_CNT = baud_divider(CLK_FREQ, BPS);

    uart_tx_state_t state_q, state_d;
    logic [3:0]     tick_cnt_q, tick_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    logic baud_tick;
    logic bit_end;

    uart_baud_gen #(
        .DIVIDER_CNT(DIVIDER_CNT)
    ) u_baud_gen (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .clear (state_q == S_IDLE),
        .tick  (baud_tick)
    );

    // Last tick of the current 16-tick bit period.
    assign bit_end = baud_tick && (tick_cnt_q == 4'd15);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        // 4-bit counter wraps 15 -> 0 on its own at each bit boundary.
        if (baud_tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (tx_if.tx_start) begin
                    state_d  = S_START_BIT;
                    shift_d  = tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_if.tx_data;
`endif
                end
            end
            S_START_BIT: begin
                if (bit_end) begin
                    state_d = S_DATA_BITS;
                end
            end
            S_DATA_BITS: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY_BIT;
`else
                        state_d = S_STOP_BIT;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY_BIT: begin
                if (bit_end) begin
                    state_d = S_STOP_BIT;
                end
            end
`endif
            S_STOP_BIT: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line value is derived from the next state so the registered output
    // changes on the same edge as the state, with no extra cycle of lag.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_IDLE:       tx_d = 1'b1;
            S_START_BIT:  tx_d = 1'b0;
            S_DATA_BITS:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY_BIT: tx_d = parity_d;
`endif
            S_STOP_BIT:   tx_d = 1'b1;
            default:      tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_if.tx      = tx_q;
    assign tx_if.tx_busy = (state_q != S_IDLE);
    assign tx_if.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx at CLK_FREQ=1_600_000, BPS=10_000
// (10 cycles per baud tick, 160 cycles per bit). Expected line bits are
// queued when a request is made and popped at each mid-bit sample.
// ---------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BIT_CYC = 160;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_if bus();

    uart_tx #(
        .CLK_FREQ(1_600_000),
        .BPS     (10_000)
    ) dut (
        .PCLK  (clk),
        .PRESET(rst_n),
        .tx_if (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    int   done_base   = 0;
    logic exp_q[$];

    always @(posedge clk) begin
        if (bus.tx_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
        end
    end

    // Step n rising edges, then move 1 time unit past the edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1.
    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
        end
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Called in acceptance cycle N; returns in cycle N+1.
    task automatic start_req(input string tag, input logic [7:0] d);
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        wait_cyc(1);
        bus.tx_start = 1'b0;
        check({tag, "_start_tx"}, 32'(bus.tx), 32'd0);
        check({tag, "_start_busy"}, 32'(bus.tx_busy), 32'd1);
    endtask

    // Called in cycle N+1; samples each bit mid-period, returns in the
    // tx_done cycle N+1+FRAME_BITS*160.
    task automatic check_frame(input string tag);
        logic e;
        wait_cyc(BIT_CYC / 2);
        for (int k = 0; k < FRAME_BITS; k++) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL %s_sb_underflow: observed empty expected bit %0d", tag, k);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_bit%0d", tag, k), 32'(bus.tx), 32'(e));
            end
            if (k < FRAME_BITS - 1) begin
                wait_cyc(BIT_CYC);
            end
        end
        wait_cyc(BIT_CYC / 2);
        check({tag, "_done"}, 32'(bus.tx_done), 32'd1);
        check({tag, "_done_busy"}, 32'(bus.tx_busy), 32'd0);
        check({tag, "_done_tx"}, 32'(bus.tx), 32'd1);
        $display("frame %s: %0d bits sampled", tag, FRAME_BITS);
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset and idle line.
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.tx_busy), 32'd0);
        check("rst_done", 32'(bus.tx_done), 32'd0);
        for (int i = 0; i < 20; i++) begin
            wait_cyc(100);
            check($sformatf("idle_tx_%0d", i), 32'(bus.tx), 32'd1);
        end
        check("idle_no_done", 32'(done_cnt), 32'd0);
        $display("reset/idle: 2000 cycles observed");

        // Single frame 0xA5.
        done_base = done_cnt;
        push_frame(8'hA5);
        start_req("a5", 8'hA5);
        check_frame("a5");
        wait_cyc(1);
        check("a5_done_pulse_width", 32'(bus.tx_done), 32'd0);
        check("a5_done_count", 32'(done_cnt - done_base), 32'd1);

        // Request at N+500 while busy must be ignored.
        done_base = done_cnt;
        push_frame(8'hA5);
        start_req("ign", 8'hA5);
        fork
            begin
                repeat (499) @(posedge clk);
                #1;
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'h3C;
                wait_cyc(1);
                bus.tx_start = 1'b0;
                bus.tx_data  = 8'hA5;
            end
        join_none
        check_frame("ign");
        wait_cyc(1);
        check("ign_done_count", 32'(done_cnt - done_base), 32'd1);
        check("ign_idle_after", 32'(bus.tx_busy), 32'd0);

        // Back-to-back with tx_start held high.
        done_base = done_cnt;
        push_frame(8'h00);
        push_frame(8'hFF);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h00;
        wait_cyc(1);
        check("b2b0_start_tx", 32'(bus.tx), 32'd0);
        check("b2b0_start_busy", 32'(bus.tx_busy), 32'd1);
        check_frame("b2b0");
        bus.tx_data = 8'hFF;
        wait_cyc(1);
        bus.tx_start = 1'b0;
        check("b2b1_start_tx", 32'(bus.tx), 32'd0);
        check("b2b1_start_busy", 32'(bus.tx_busy), 32'd1);
        check_frame("b2b1");
        wait_cyc(1);
        check("b2b_done_count", 32'(done_cnt - done_base), 32'd2);

        // Reset in the middle of a frame.
        done_base = done_cnt;
        start_req("abort", 8'hC3);
        wait_cyc(699);
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        check("abort_tx", 32'(bus.tx), 32'd1);
        check("abort_busy", 32'(bus.tx_busy), 32'd0);
        check("abort_done", 32'(bus.tx_done), 32'd0);
        wait_cyc(1700);
        check("abort_no_done", 32'(done_cnt - done_base), 32'd0);
        check("abort_line_idle", 32'(bus.tx), 32'd1);
        $display("frame abort: reset mid-frame observed");

        push_frame(8'h5A);
        start_req("5a", 8'h5A);
        check_frame("5a");
        wait_cyc(1);
        check("5a_done_count", 32'(done_cnt - done_base), 32'd1);

        // Parity-sensitive patterns (odd and even popcount).
        done_base = done_cnt;
        push_frame(8'h07);
        start_req("07", 8'h07);
        check_frame("07");
        wait_cyc(1);
        push_frame(8'h03);
        start_req("03", 8'h03);
        check_frame("03");
        wait_cyc(1);
        check("par_done_count", 32'(done_cnt - done_base), 32'd2);

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
